univ_mod_counter: RTL and testbench

Next-generation universal counter. Adds a run-time programmable terminal value (modulus), a variable step size, and wrap-or-saturate boundary mode. Adds a registered boundary-event pulse and a sticky overflow flag. Used as a programmable timebase/event counter; its wrap_pulse drives enables of downstream units.

---
 rtl/univ_mod_counter_pkg.sv | 20 ++
 rtl/univ_mod_counter_if.sv | 32 +++
 rtl/univ_mod_counter_mod_step_unit.sv | 55 +++++
 rtl/univ_mod_counter.sv | 71 +++++++
 tb/tb_univ_mod_counter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/univ_mod_counter_pkg.sv
// Shared constants and helpers for the universal modulo counter.
// Boundary mode encoding, count direction and reset-limit helper.
package univ_cnt_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // All-ones value of width n; callers size-cast it to their own width.
    function automatic logic [63:0] reset_lim(input int unsigned n);
        if (n >= 64)
            return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

endpackage

// File: rtl/univ_mod_counter_if.sv
// Control/status bundle of univ_mod_counter; clk and reset_n stay outside.
// master drives the controls, slave is the counter itself.
interface univ_mod_counter_if #(
    parameter int N      = 8,
    parameter int STEP_W = 4
);
    logic              syn_clr;
    logic              load;
    logic [N-1:0]      d;
    logic              en;
    logic              up;
    logic [STEP_W-1:0] step;
    logic              sat;
    logic              mod_wr;
    logic [N-1:0]      mod_d;
    logic [N-1:0]      q;
    logic [N-1:0]      lim;
    logic              max_tick;
    logic              min_tick;
    logic              wrap_pulse;
    logic              ovf_sticky;

    modport master (
        output syn_clr, load, d, en, up, step, sat, mod_wr, mod_d,
        input  q, lim, max_tick, min_tick, wrap_pulse, ovf_sticky
    );

    modport slave (
        input  syn_clr, load, d, en, up, step, sat, mod_wr, mod_d,
        output q, lim, max_tick, min_tick, wrap_pulse, ovf_sticky
    );
endinterface

// File: rtl/univ_mod_counter_mod_step_unit.sv
// Combinational step/clamp/wrap/saturate datapath for one enabled count cycle.
// Works on N+1-bit intermediates so q+step never silently truncates.
module mod_step_unit
    import univ_cnt_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic [N-1:0]      q,
    input  logic [N-1:0]      lim,
    input  logic [STEP_W-1:0] step,
    input  logic              up,
    input  logic              sat,
    output logic [N-1:0]      q_next,
    output logic              boundary
);
    logic [N:0] qc, lx, l1, st, s;

    always_comb begin
        lx       = {1'b0, lim};
        l1       = lx + {{N{1'b0}}, 1'b1};
        st       = (N+1)'(step);
        qc       = (q > lim) ? lx : {1'b0, q};
        s        = qc + st;
        q_next   = N'(qc);
        boundary = 1'b0;

        if (dir_e'(up) == DIR_UP) begin
            if (s <= lx) begin
                q_next = N'(s);
            end else begin
                boundary = 1'b1;
                if (sat == MODE_SAT)
                    q_next = lim;
                else if (st <= l1)
                    q_next = N'(s - l1);
                else
                    q_next = '0;
            end
        end else begin
            if (st <= qc) begin
                q_next = N'(qc - st);
            end else begin
                boundary = 1'b1;
                if (sat == MODE_SAT)
                    q_next = '0;
                else if (st <= l1)
                    // qc < st <= L+1, so the sum stays within 0..L
                    q_next = N'(qc + l1 - st);
                else
                    q_next = lim;
            end
        end
    end
endmodule

// File: rtl/univ_mod_counter.sv
// Universal counter: programmable limit, variable step, wrap/saturate mode,
// registered boundary pulse and sticky overflow flag.
module univ_mod_counter
    import univ_cnt_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input logic               clk,
    input logic               reset_n,
    univ_mod_counter_if.slave bus
);
    localparam logic [N-1:0] LIM_RST = N'(reset_lim(N));

    logic [N-1:0] q_reg, lim_reg, lim_next, q_sel, q_step;
    logic         pulse_reg, sticky_reg, pulse_next, sticky_next;
    logic         boundary;

    // A same-cycle limit write governs this cycle's load/count/clamp.
    assign lim_next = bus.mod_wr ? bus.mod_d : lim_reg;

    mod_step_unit #(.N(N), .STEP_W(STEP_W)) u_step (
        .q        (q_reg),
        .lim      (lim_next),
        .step     (bus.step),
        .up       (bus.up),
        .sat      (bus.sat),
        .q_next   (q_step),
        .boundary (boundary)
    );

    always_comb begin
        q_sel       = q_reg;
        pulse_next  = 1'b0;
        sticky_next = sticky_reg;
        if (bus.syn_clr) begin
            q_sel       = '0;
            sticky_next = 1'b0;
        end else if (bus.load) begin
            q_sel = (bus.d > lim_next) ? lim_next : bus.d;
        end else if (bus.en) begin
            q_sel      = q_step;
            pulse_next = boundary;
            if (boundary)
                sticky_next = 1'b1;
        end else if (q_reg > lim_next) begin
            q_sel = lim_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg      <= '0;
            lim_reg    <= LIM_RST;
            pulse_reg  <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            q_reg      <= q_sel;
            lim_reg    <= lim_next;
            pulse_reg  <= pulse_next;
            sticky_reg <= sticky_next;
        end
    end

    assign bus.q          = q_reg;
    assign bus.lim        = lim_reg;
    assign bus.max_tick   = (q_reg == lim_reg);
    assign bus.min_tick   = (q_reg == '0);
    assign bus.wrap_pulse = pulse_reg;
    assign bus.ovf_sticky = sticky_reg;
endmodule

// File: tb/tb_univ_mod_counter.sv
// Directed plus randomized bench for univ_mod_counter against an integer model.
module tb_univ_mod_counter;
    localparam int N      = 8;
    localparam int STEP_W = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state (plain integers)
    int mq, mlim, mpulse, msticky;

    univ_mod_counter_if #(.N(N), .STEP_W(STEP_W)) bus ();

    univ_mod_counter #(.N(N), .STEP_W(STEP_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},      32'(bus.q),      32'(mq));
        check({tag, ".lim"},    32'(bus.lim),    32'(mlim));
        check({tag, ".pulse"},  32'(bus.wrap_pulse), 32'(mpulse));
        check({tag, ".sticky"}, 32'(bus.ovf_sticky), 32'(msticky));
        check({tag, ".max"},    32'(bus.max_tick), 32'(mq == mlim));
        check({tag, ".min"},    32'(bus.min_tick), 32'(mq == 0));
    endtask

    task automatic model_reset();
        mq = 0; mlim = (1 << N) - 1; mpulse = 0; msticky = 0;
    endtask

    // Rules evaluated directly on integers: the count lives in 0..L, with
    // wrap as arithmetic modulo L+1.
    task automatic model_edge();
        int L, qc, st;
        L      = bus.mod_wr ? int'(bus.mod_d) : mlim;
        st     = int'(bus.step);
        mpulse = 0;
        if (bus.syn_clr) begin
            mq = 0; msticky = 0;
        end else if (bus.load) begin
            mq = (int'(bus.d) < L) ? int'(bus.d) : L;
        end else if (bus.en) begin
            qc = (mq < L) ? mq : L;
            if (bus.up) begin
                if (qc + st <= L) mq = qc + st;
                else begin
                    mpulse = 1;
                    mq = bus.sat ? L : ((st <= L + 1) ? (qc + st) % (L + 1) : 0);
                end
            end else begin
                if (st <= qc) mq = qc - st;
                else begin
                    mpulse = 1;
                    mq = bus.sat ? 0 : ((st <= L + 1) ? (qc - st + L + 1) % (L + 1) : L);
                end
            end
            if (mpulse != 0) msticky = 1;
        end else if (mq > L) begin
            mq = L;
        end
        mlim = L;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        bus.syn_clr = 0; bus.load = 0; bus.d = '0; bus.en = 0; bus.up = 1;
        bus.step = '0; bus.sat = 0; bus.mod_wr = 0; bus.mod_d = '0;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        check("rst.lim_ff", 32'(bus.lim), 32'hFF);
        reset_n = 1'b1;

        // Count from 0x37 then drop reset between edges
        bus.load = 1; bus.d = 8'h37;
        tick("ld37");
        check("ld37.q", 32'(bus.q), 32'h37);
        bus.load = 0; bus.en = 1; bus.up = 1; bus.step = 4'd1;
        tick("cnt38");
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        check("arst.min", 32'(bus.min_tick), 32'd1);
        @(negedge clk);
        idle();
        reset_n = 1'b1;

        // Modulo-10 up count with step 3
        bus.mod_wr = 1; bus.mod_d = 8'd9; bus.en = 1; bus.up = 1; bus.step = 4'd3;
        tick("m10a"); check("m10a.q", 32'(bus.q), 32'd3);
        bus.mod_wr = 0;
        tick("m10b"); check("m10b.q", 32'(bus.q), 32'd6);
        tick("m10c"); check("m10c.q", 32'(bus.q), 32'd9);
        check("m10c.pulse", 32'(bus.wrap_pulse), 32'd0);
        tick("m10d"); check("m10d.q", 32'(bus.q), 32'd2);
        check("m10d.pulse", 32'(bus.wrap_pulse), 32'd1);
        check("m10d.sticky", 32'(bus.ovf_sticky), 32'd1);

        // Saturating down count
        idle(); bus.load = 1; bus.d = 8'd4;
        tick("sdld");
        idle(); bus.en = 1; bus.up = 0; bus.sat = 1; bus.step = 4'd3;
        tick("sd1"); check("sd1.q", 32'(bus.q), 32'd1);
        tick("sd2"); check("sd2.pulse", 32'(bus.wrap_pulse), 32'd1);
        tick("sd3"); check("sd3.pulse", 32'(bus.wrap_pulse), 32'd1);
        check("sd3.q", 32'(bus.q), 32'd0);
        check("sd3.min", 32'(bus.min_tick), 32'd1);

        // Limit shrink clamps a held count; load clamps to the limit
        idle(); bus.load = 1; bus.d = 8'd8;
        tick("shld");
        idle(); bus.mod_wr = 1; bus.mod_d = 8'd5;
        tick("shr"); check("shr.q", 32'(bus.q), 32'd5);
        check("shr.pulse", 32'(bus.wrap_pulse), 32'd0);
        idle(); bus.load = 1; bus.d = 8'd200;
        tick("ldclamp"); check("ldclamp.q", 32'(bus.q), 32'd5);
        check("ldclamp.max", 32'(bus.max_tick), 32'd1);

        // Everything at once: clear wins, limit still written
        check("prio.pre_sticky", 32'(bus.ovf_sticky), 32'd1);
        idle(); bus.syn_clr = 1; bus.load = 1; bus.d = 8'd7; bus.en = 1;
        bus.step = 4'd1; bus.mod_wr = 1; bus.mod_d = 8'd12;
        tick("prio"); check("prio.lim", 32'(bus.lim), 32'd12);
        check("prio.sticky", 32'(bus.ovf_sticky), 32'd0);
        check("prio.q", 32'(bus.q), 32'd0);

        // Down-wrap where step exceeds L+1
        idle(); bus.mod_wr = 1; bus.mod_d = 8'd5; bus.load = 1; bus.d = 8'd1;
        tick("dwld");
        idle(); bus.en = 1; bus.up = 0; bus.sat = 0; bus.step = 4'd7;
        tick("dw1"); check("dw1.q", 32'(bus.q), 32'd5);
        check("dw1.pulse", 32'(bus.wrap_pulse), 32'd1);
        bus.step = 4'd4;
        tick("dw2"); check("dw2.q", 32'(bus.q), 32'd1);
        check("dw2.pulse", 32'(bus.wrap_pulse), 32'd0);

        // Randomized traffic, small limits favoured to hit boundaries often
        for (int i = 0; i < 400; i++) begin
            bus.syn_clr = ($urandom_range(0, 29) == 0);
            bus.load    = ($urandom_range(0, 11) == 0);
            bus.d       = N'($urandom_range(0, 255));
            bus.en      = ($urandom_range(0, 4) != 0);
            bus.up      = 1'($urandom_range(0, 1));
            bus.step    = STEP_W'($urandom_range(0, 15));
            bus.sat     = 1'($urandom_range(0, 1));
            bus.mod_wr  = ($urandom_range(0, 9) == 0);
            bus.mod_d   = ($urandom_range(0, 1) != 0) ? N'($urandom_range(0, 15))
                                                      : N'($urandom_range(0, 255));
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
